sirv_mrom_rd_seq: RTL and testbench

Read-side initiator for the mask-ROM word interface. It drives rom_addr and samples the combinational rom_dout.
On a start request it reads a programmable run of consecutive ROM words. Each word is presented on a valid/ready stream with its byte address, and a running 32-bit checksum is accumulated.
Used for boot-image copy-out and ROM self-check ahead of the ITCM.

---
 rtl/sirv_mrom_rd_seq_if.sv | 13 +
 rtl/sirv_mrom_rd_seq.sv | 122 ++++++++++++
 tb/tb_sirv_mrom_rd_seq.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sirv_mrom_rd_seq_if.sv
// Word stream from the mask-ROM read sequencer: one ROM word plus its byte address per handshake.
interface sirv_mrom_rd_seq_if #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 32
);
  logic          o_valid;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic [AW-1:0] o_addr;

  modport master (output o_valid, output o_data, output o_addr, input o_ready);
  modport slave  (input o_valid, input o_data, input o_addr, output o_ready);
endinterface

// File: rtl/sirv_mrom_rd_seq.sv
// Mask-ROM read sequencer: streams a run of consecutive ROM words with byte addresses
// and accumulates a modulo-2^DW checksum of the accepted words.
module sirv_mrom_rd_seq #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [AW-3:0]       start_idx,
  input  logic [AW-2:0]       word_cnt,
  output logic [AW-3:0]       rom_addr,
  input  logic [DW-1:0]       rom_dout,
  sirv_mrom_rd_seq_if.master  strm,
  output logic                busy,
  output logic                done,
  output logic [DW-1:0]       chksum
);

  localparam int unsigned IW = AW - 2;
  localparam int unsigned CW = AW - 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]    state_q,  state_d;
  logic [IW-1:0] idx_q,    idx_d;
  logic [CW-1:0] rem_q,    rem_d;
  logic          valid_q,  valid_d;
  logic [DW-1:0] data_q,   data_d;
  logic [AW-1:0] addr_q,   addr_d;
  logic          busy_q,   busy_d;
  logic          done_q,   done_d;
  logic [DW-1:0] chksum_q, chksum_d;

  // Next-state and datapath; rom_dout always reflects idx_q, which is pre-advanced to the next word.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    valid_d  = valid_q;
    data_d   = data_q;
    addr_d   = addr_q;
    chksum_d = chksum_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d    = start_idx;
          rem_d    = word_cnt;
          chksum_d = '0;
          state_d  = (word_cnt != '0) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: begin
        data_d  = rom_dout;
        addr_d  = {idx_q, 2'b00};
        valid_d = 1'b1;
        idx_d   = idx_q + IW'(1);
        state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (valid_q && strm.o_ready) begin
          chksum_d = chksum_q + data_q;
          if (rem_q == CW'(1)) begin
            valid_d = 1'b0;
            state_d = S_DONE;
          end else begin
            rem_d  = rem_q - CW'(1);
            data_d = rom_dout;
            addr_d = {idx_q, 2'b00};
            idx_d  = idx_q + IW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      rem_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      chksum_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      chksum_q <= chksum_d;
    end
  end

  assign rom_addr     = idx_q;
  assign strm.o_valid = valid_q;
  assign strm.o_data  = data_q;
  assign strm.o_addr  = addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign chksum       = chksum_q;

endmodule

// File: tb/tb_sirv_mrom_rd_seq.sv
// Scoreboard bench for sirv_mrom_rd_seq: directed scenarios plus randomized runs against a ROM-walk model.
module tb_sirv_mrom_rd_seq;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-3:0] start_idx;
  logic [AW-2:0] word_cnt;
  logic [AW-3:0] rom_addr;
  logic [DW-1:0] rom_dout;
  logic          busy;
  logic          done;
  logic [DW-1:0] chksum;
  logic [DW-1:0] rom [NW];

  sirv_mrom_rd_seq_if #(.AW(AW), .DW(DW)) s_if ();

  sirv_mrom_rd_seq #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_idx (start_idx),
    .word_cnt  (word_cnt),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .strm      (s_if),
    .busy      (busy),
    .done      (done),
    .chksum    (chksum)
  );

  assign rom_dout = rom[rom_addr];
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
  } word_t;

  word_t         exp_q[$];
  logic [DW-1:0] exp_sum_q[$];
  int            passed = 0;
  int            total = 0;
  int            hs_cnt = 0;
  int            done_cnt = 0;
  int            done_base = 0;
  bit            rdy_rand = 1'b0;
  bit            stall_v = 1'b0;
  word_t         stall_w;
  word_t         mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a run is just the words at (start_idx + k) mod NW, summed modulo 2^DW.
  task automatic model_run(input int sidx, input int cnt);
    logic [DW-1:0] sum;
    word_t         w;
    int            wi;
    sum = '0;
    for (int k = 0; k < cnt; k++) begin
      wi     = (sidx + k) % NW;
      w.data = rom[wi];
      w.addr = AW'(wi * 4);
      exp_q.push_back(w);
      sum = sum + rom[wi];
    end
    exp_sum_q.push_back(sum);
  endtask

  task automatic run_start(input int sidx, input int cnt);
    model_run(sidx, cnt);
    done_base = done_cnt;
    start_idx = (AW-2)'(sidx);
    word_cnt  = (AW-1)'(cnt);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == done_base; i++) tick();
    chk("done_timeout", 64'(done_cnt > done_base), 64'(1));
    tick();
  endtask

  // Monitor: checks every accepted word and every done pulse against the scoreboard queues.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (stall_v && s_if.o_valid) begin
          chk("stall_data", 64'(s_if.o_data), 64'(stall_w.data));
          chk("stall_addr", 64'(s_if.o_addr), 64'(stall_w.addr));
        end
        stall_v      = s_if.o_valid && !s_if.o_ready;
        stall_w.data = s_if.o_data;
        stall_w.addr = s_if.o_addr;
        if (s_if.o_valid && s_if.o_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) chk("unexpected_word", 64'(1), 64'(0));
          else begin
            mon_e = exp_q.pop_front();
            chk("word_data", 64'(s_if.o_data), 64'(mon_e.data));
            chk("word_addr", 64'(s_if.o_addr), 64'(mon_e.addr));
          end
        end
        if (done) begin
          done_cnt++;
          if (exp_sum_q.size() == 0) chk("unexpected_done", 64'(1), 64'(0));
          else chk("done_chksum", 64'(chksum), 64'(exp_sum_q.pop_front()));
        end
      end else begin
        stall_v = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) s_if.o_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int hs0;
    int d0;
    rst         = 1'b1;
    start       = 1'b1;
    start_idx   = '0;
    word_cnt    = '0;
    s_if.o_ready = 1'b0;
    for (int i = 0; i < int'(NW); i++) rom[i] = '0;
    rom[0] = 32'h7ffff297;
    rom[1] = 32'h00028067;

    // Reset held with start asserted
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid",  64'(s_if.o_valid), 64'(0));
    chk("rst_busy",   64'(busy), 64'(0));
    chk("rst_done",   64'(done), 64'(0));
    chk("rst_chksum", 64'(chksum), 64'(0));
    chk("rst_romaddr", 64'(rom_addr), 64'(0));
    chk("rst_data",   64'(s_if.o_data), 64'(0));
    chk("rst_addr",   64'(s_if.o_addr), 64'(0));
    tick();
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("idle_busy",  64'(busy), 64'(0));
    chk("idle_valid", 64'(s_if.o_valid), 64'(0));
    tick();

    // Basic run with o_ready high, cycle-exact
    s_if.o_ready = 1'b1;
    run_start(0, 2);
    @(negedge clk);
    chk("basic_fetch_busy",  64'(busy), 64'(1));
    chk("basic_fetch_valid", 64'(s_if.o_valid), 64'(0));
    tick();
    @(negedge clk);
    chk("basic_w0_valid", 64'(s_if.o_valid), 64'(1));
    chk("basic_w0_data",  64'(s_if.o_data), 64'h7ffff297);
    chk("basic_w0_addr",  64'(s_if.o_addr), 64'h000);
    tick();
    @(negedge clk);
    chk("basic_w1_data",  64'(s_if.o_data), 64'h00028067);
    chk("basic_w1_addr",  64'(s_if.o_addr), 64'h004);
    tick();
    @(negedge clk);
    chk("basic_done",   64'(done), 64'(1));
    chk("basic_valid0", 64'(s_if.o_valid), 64'(0));
    chk("basic_chksum", 64'(chksum), 64'h800272FE);
    tick();
    @(negedge clk);
    chk("basic_done_pulse", 64'(done), 64'(0));
    chk("basic_idle_busy",  64'(busy), 64'(0));
    tick();

    // Backpressure: o_ready low for 5 cycles
    hs0 = hs_cnt;
    s_if.o_ready = 1'b0;
    run_start(0, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        chk("bp_valid", 64'(s_if.o_valid), 64'(1));
        chk("bp_data",  64'(s_if.o_data), 64'h7ffff297);
        chk("bp_addr",  64'(s_if.o_addr), 64'h000);
      end
      tick();
    end
    s_if.o_ready = 1'b1;
    wait_done(50);
    chk("bp_chksum", 64'(chksum), 64'h800272FE);
    chk("bp_handshakes", 64'(hs_cnt - hs0), 64'(2));

    // Index wrap past the last ROM word
    run_start(1023, 2);
    wait_done(50);
    chk("wrap_chksum", 64'(chksum), 64'h7ffff297);

    // Zero-length run
    run_start(0, 0);
    @(negedge clk);
    chk("zero_done",   64'(done), 64'(1));
    chk("zero_valid",  64'(s_if.o_valid), 64'(0));
    chk("zero_chksum", 64'(chksum), 64'(0));
    tick();
    @(negedge clk);
    chk("zero_done_pulse", 64'(done), 64'(0));
    tick();

    // Start pulses during a 4-word run are ignored
    hs0 = hs_cnt;
    run_start(2, 4);
    d0 = done_base;
    tick();
    start_idx = 10'd5;
    word_cnt  = 11'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(50);
    repeat (12) tick();
    chk("ign_handshakes", 64'(hs_cnt - hs0), 64'(4));
    chk("ign_dones", 64'(done_cnt - d0), 64'(1));

    // Reset after the first handshake of a 3-word run
    hs0 = hs_cnt;
    run_start(0, 3);
    tick();
    tick();
    rst = 1'b1;
    d0 = done_cnt;
    tick();
    @(negedge clk);
    chk("mrst_valid",  64'(s_if.o_valid), 64'(0));
    chk("mrst_busy",   64'(busy), 64'(0));
    chk("mrst_chksum", 64'(chksum), 64'(0));
    chk("mrst_done",   64'(done), 64'(0));
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_sum_q.delete();
    repeat (6) tick();
    chk("mrst_no_done", 64'(done_cnt), 64'(d0));
    chk("mrst_handshakes", 64'(hs_cnt - hs0), 64'(1));

    // Randomized runs over random ROM contents with random backpressure
    for (int i = 0; i < int'(NW); i++) rom[i] = $urandom;
    rdy_rand = 1'b1;
    for (int r = 0; r < 25; r++) begin
      int cnt;
      cnt = (r == 0) ? int'(NW) : int'($urandom_range(0, 24));
      run_start(int'($urandom_range(0, NW - 1)), cnt);
      wait_done(6000);
      repeat ($urandom_range(0, 2)) tick();
    end
    rdy_rand = 1'b0;
    s_if.o_ready = 1'b1;
    repeat (4) tick();
    chk("sb_words_left", 64'(exp_q.size()), 64'(0));
    chk("sb_sums_left",  64'(exp_sum_q.size()), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
